fib_rx: RTL and testbench

Clocked receiver for the asynchronous `link_intf` bundled-data channel driven by the Fibonacci source. It synchronises the link request into the `clk` domain and latches the data word. It then presents the word on a valid/ready port to synchronous logic and returns the acknowledge once that port accepts the word. An optional checker compares every received word against a locally generated Fibonacci sequence and counts mismatches.

---
 rtl/fib_rx_if.sv | 12 +
 rtl/fib_rx.sv | 123 ++++++++++++
 tb/tb_fib_rx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_rx_if.sv
// link_intf: asynchronous bundled-data link carrying one WIDTH-bit word per
// req phase (two-phase) or per req pulse (four-phase).
interface link_intf #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] data;

    modport in  (input  req, input  data, output ack);
    modport out (output req, output data, input  ack);
endinterface

// File: rtl/fib_rx.sv
// fib_rx: clock-domain receiver for the link_intf bundled-data channel, with a
// valid/ready output port. Define FIB_RX_CHECK_EN to add the Fibonacci checker.
module fib_rx #(
    parameter     ENC         = "TP",
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    link_intf.in             in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      word_cnt,
    output logic             err,
    output logic [15:0]      err_cnt
);

    localparam bit FOUR_PHASE = (ENC == "FP");

    typedef enum logic [1:0] {IDLE, HOLD, RTZ} state_t;

    state_t                 state;
    logic                   ack_r;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_event;
    logic                   accept;

    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would make chained flops collapse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], in.req};
    end

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign req_event = FOUR_PHASE ? req_s : (req_s != ack_r);
    assign accept    = out_valid && out_ready;

    // Data is captured only when the synchronised req says a word is present;
    // the sender holds it stable until ack answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack_r     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_event) begin
                        out_data  <= in.data;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (FOUR_PHASE) begin
                            ack_r <= 1'b1;
                            state <= RTZ;
                        end else begin
                            ack_r <= ~ack_r;
                            state <= IDLE;
                        end
                    end
                end
                RTZ: begin
                    if (!req_s) begin
                        ack_r <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in.ack = ack_r;

    // A start coinciding with an accept counts that word as the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      word_cnt <= '0;
        else if (start)  word_cnt <= accept ? 32'd1 : 32'd0;
        else if (accept) word_cnt <= word_cnt + 32'd1;
    end

`ifdef FIB_RX_CHECK_EN
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic             mismatch;

    assign mismatch = accept && (out_data != (start ? '0 : exp_a));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_a   <= '0;
            exp_b   <= WIDTH'(1);
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= mismatch;
            if (start) begin
                // Restarted sequence is 0,1; an accepted word advances it once.
                exp_a   <= accept ? WIDTH'(1) : '0;
                exp_b   <= WIDTH'(1);
                err_cnt <= mismatch ? 16'd1 : 16'd0;
            end else if (accept) begin
                exp_a <= exp_b;
                exp_b <= exp_a + exp_b;
                if (mismatch && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fib_rx.sv
// tb_fib_rx: directed checks of fib_rx in two-phase, four-phase and 8-bit
// two-phase configurations sharing one clock and reset.
module tb_fib_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, rdy_t, rdy_f, rdy_8;

    link_intf #(.WIDTH(32)) lt ();
    link_intf #(.WIDTH(32)) lf ();
    link_intf #(.WIDTH(8))  l8 ();

    logic        v_t, v_f, v_8;
    logic [31:0] d_t, d_f;
    logic [7:0]  d_8;
    logic [31:0] wc_t, wc_f, wc_8;
    logic        e_t, e_f, e_8;
    logic [15:0] ec_t, ec_f, ec_8;

    fib_rx #(.ENC("TP"), .WIDTH(32), .SYNC_STAGES(2)) dut_tp (
        .clk(clk), .rst_n(rst_n), .start(start), .in(lt),
        .out_valid(v_t), .out_ready(rdy_t), .out_data(d_t),
        .word_cnt(wc_t), .err(e_t), .err_cnt(ec_t)
    );

    fib_rx #(.ENC("FP"), .WIDTH(32), .SYNC_STAGES(2)) dut_fp (
        .clk(clk), .rst_n(rst_n), .start(start), .in(lf),
        .out_valid(v_f), .out_ready(rdy_f), .out_data(d_f),
        .word_cnt(wc_f), .err(e_f), .err_cnt(ec_f)
    );

    fib_rx #(.ENC("TP"), .WIDTH(8), .SYNC_STAGES(2)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .start(start), .in(l8),
        .out_valid(v_8), .out_ready(rdy_8), .out_data(d_8),
        .word_cnt(wc_8), .err(e_8), .err_cnt(ec_8)
    );

`ifdef FIB_RX_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    always @(negedge clk) if (e_t) err_pulses <= err_pulses + 1;

    int fib10 [10]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    int fib8  [15]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
    int bad5  [7]   = '{0, 1, 1, 2, 4, 5, 8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Toggle req with a new word and wait (bounded) for out_valid.
    task automatic tp_present(input logic [31:0] d);
        int n;
        @(negedge clk);
        lt.data = d;
        lt.req  = ~lt.req;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!v_t && n < 10);
        check("tp_latency", n, 3);
        check("tp_data", d_t, d);
    endtask

    task automatic tp_word(input logic [31:0] d);
        tp_present(d);
        @(negedge clk);
        check("tp_ack", lt.ack, lt.req);
        check("tp_valid_fall", v_t, 0);
    endtask

    task automatic fp_word(input logic [31:0] d, input int idx);
        int n;
        @(negedge clk);
        lf.data = d;
        lf.req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!v_f && n < 10);
        check("fp_latency", n, 3);
        check("fp_data", d_f, d);
        @(negedge clk);
        check("fp_ack_rise", lf.ack, 1);
        check("fp_valid_fall", v_f, 0);
        check("fp_word_cnt", wc_f, idx + 1);
        lf.req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lf.ack && n < 10);
        check("fp_release", n, 3);
        check("fp_valid_idle", v_f, 0);
    endtask

    task automatic w8_word(input logic [7:0] d);
        int n;
        @(negedge clk);
        l8.data = d;
        l8.req  = ~l8.req;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!v_8 && n < 10);
        check("w8_latency", n, 3);
        check("w8_data", d_8, d);
        @(negedge clk);
        check("w8_ack", l8.ack, l8.req);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        start = 1'b0;
        rdy_t = 1'b1;
        rdy_f = 1'b1;
        rdy_8 = 1'b1;
        lt.req = 1'b0; lt.data = '0;
        lf.req = 1'b0; lf.data = '0;
        l8.req = 1'b0; l8.data = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", v_t, 0);
        check("rst_data", d_t, 0);
        check("rst_word_cnt", wc_t, 0);
        check("rst_ack", lt.ack, 0);
        check("rst_err", e_t, 0);
        check("rst_err_cnt", ec_t, 0);
        check("rst_fp_ack", lf.ack, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-phase stream with ready tied high.
        for (int i = 0; i < 10; i++) tp_word(fib10[i]);
        check("tp_word_cnt", wc_t, 10);
        check("tp_err_cnt", ec_t, 0);

        // Backpressure: word held for 20 cycles, ack frozen.
        rdy_t = 1'b0;
        tp_present(55);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!v_t || d_t != 32'd55 || lt.ack == lt.req) bad++;
        end
        check("bp_stable", bad, 0);
        rdy_t = 1'b1;
        @(negedge clk);
        check("bp_ack", lt.ack, lt.req);
        check("bp_valid_fall", v_t, 0);
        check("bp_word_cnt", wc_t, 11);
        check("bp_err_cnt", ec_t, 0);

        // Four-phase stream.
        for (int i = 0; i < 10; i++) fp_word(fib10[i], i);
        check("fp_word_cnt_end", wc_f, 10);
        check("fp_err_cnt", ec_f, 0);

        // 8-bit width: sequence wraps modulo 256 without error.
        for (int i = 0; i < 15; i++) w8_word(fib8[i][7:0]);
        check("w8_word_cnt", wc_8, 15);
        check("w8_err_cnt", ec_8, 0);

        // Restart, then corrupt the fifth word.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_word_cnt", wc_t, 0);
        for (int i = 0; i < 7; i++) tp_word(bad5[i]);
        @(negedge clk);
        check("bad_word_cnt", wc_t, 7);
        check("bad_err_cnt", ec_t, CHK);
        check("bad_err_pulses", err_pulses, CHK);

        // Reset while holding a word.
        rdy_t = 1'b0;
        tp_present(77);
        @(negedge clk);
        rst_n  = 1'b0;
        lt.req = 1'b0;
        #1;
        check("hold_rst_valid", v_t, 0);
        check("hold_rst_data", d_t, 0);
        check("hold_rst_ack", lt.ack, 0);
        check("hold_rst_word_cnt", wc_t, 0);
        check("hold_rst_err_cnt", ec_t, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First word accepted in the same cycle as start counts as word 1.
        tp_present(0);
        @(negedge clk);
        start = 1'b1;
        rdy_t = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_acc_word_cnt", wc_t, 1);
        check("start_acc_ack", lt.ack, lt.req);
        check("start_acc_err_cnt", ec_t, 0);
        tp_word(1);
        tp_word(1);
        tp_word(2);
        @(negedge clk);
        check("restart_word_cnt", wc_t, 4);
        check("restart_err_cnt", ec_t, 0);
        check("restart_err_pulses", err_pulses, CHK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
